// File: rtl/alu_seq.sv
// alu_seq: multi-cycle PIC-style ALU with W accumulator, registered C/DC/Z flags,
// a START/BUSY/DONE handshake and iterative unsigned multiply/divide.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [4:0]       OP,
    input  logic             WE,
    input  logic [BW-1:0]    B,
    input  logic [WIDTH-1:0] FI,
    input  logic             CI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] FO,
    output logic [WIDTH-1:0] FO_HI,
    output logic             CO,
    output logic             DC,
    output logic             Z
);

    localparam int unsigned Half = WIDTH / 2;

    localparam logic [4:0] OpPsw = 5'h00;
    localparam logic [4:0] OpClr = 5'h01;
    localparam logic [4:0] OpAdd = 5'h02;
    localparam logic [4:0] OpSub = 5'h03;
    localparam logic [4:0] OpDec = 5'h04;
    localparam logic [4:0] OpInc = 5'h05;
    localparam logic [4:0] OpIor = 5'h06;
    localparam logic [4:0] OpAnd = 5'h07;
    localparam logic [4:0] OpXor = 5'h08;
    localparam logic [4:0] OpPsf = 5'h09;
    localparam logic [4:0] OpCom = 5'h0A;
    localparam logic [4:0] OpRrf = 5'h0B;
    localparam logic [4:0] OpRlf = 5'h0C;
    localparam logic [4:0] OpSwp = 5'h0D;
    localparam logic [4:0] OpBcf = 5'h0E;
    localparam logic [4:0] OpBsf = 5'h0F;
    localparam logic [4:0] OpBtf = 5'h10;
    localparam logic [4:0] OpMul = 5'h11;
    localparam logic [4:0] OpDiv = 5'h12;

    typedef enum logic [1:0] {StIdle, StIter, StFin} state_e;

    state_e           state_q, state_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] hi_q, hi_d;       // partial product high / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0] fo_q, fo_d;
    logic [WIDTH-1:0] fo_hi_q, fo_hi_d;
    logic             co_q, co_d;
    logic             dc_q, dc_d;
    logic             z_q, z_d;
    logic             done_q, done_d;

    // Single-cycle datapath signals
    logic [WIDTH:0]   add_full, sub_full;
    logic [Half:0]    add_half, sub_half;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] s_fo;
    logic             s_co, s_dc, s_z;
    logic             s_upd_co, s_upd_dc, s_upd_z;

    // Iteration step signals
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_s, trial;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign add_full = {1'b0, FI} + {1'b0, w_q};
    assign sub_full = {1'b0, FI} + {1'b0, ~w_q} + {{WIDTH{1'b0}}, 1'b1};
    assign add_half = {1'b0, FI[Half-1:0]} + {1'b0, w_q[Half-1:0]};
    assign sub_half = {1'b0, FI[Half-1:0]} + {1'b0, ~w_q[Half-1:0]} + {{Half{1'b0}}, 1'b1};
    assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << B;

    // Single-cycle operation result and which flags it updates
    always_comb begin
        s_fo     = '0;
        s_co     = 1'b0;
        s_dc     = 1'b0;
        s_z      = 1'b0;
        s_upd_co = 1'b0;
        s_upd_dc = 1'b0;
        s_upd_z  = 1'b1;
        case (OP)
            OpPsw: s_fo = w_q;
            OpClr: s_fo = '0;
            OpAdd: begin
                s_fo     = add_full[WIDTH-1:0];
                s_co     = add_full[WIDTH];
                s_dc     = add_half[Half];
                s_upd_co = 1'b1;
                s_upd_dc = 1'b1;
            end
            OpSub: begin
                s_fo     = sub_full[WIDTH-1:0];
                s_co     = sub_full[WIDTH];
                s_dc     = sub_half[Half];
                s_upd_co = 1'b1;
                s_upd_dc = 1'b1;
            end
            OpDec: s_fo = FI - {{(WIDTH-1){1'b0}}, 1'b1};
            OpInc: s_fo = FI + {{(WIDTH-1){1'b0}}, 1'b1};
            OpIor: s_fo = FI | w_q;
            OpAnd: s_fo = FI & w_q;
            OpXor: s_fo = FI ^ w_q;
            OpPsf: s_fo = FI;
            OpCom: s_fo = ~FI;
            OpRrf: begin
                s_fo     = {CI, FI[WIDTH-1:1]};
                s_co     = FI[0];
                s_upd_co = 1'b1;
                s_upd_z  = 1'b0;
            end
            OpRlf: begin
                s_fo     = {FI[WIDTH-2:0], CI};
                s_co     = FI[WIDTH-1];
                s_upd_co = 1'b1;
                s_upd_z  = 1'b0;
            end
            OpSwp: begin
                s_fo    = {FI[Half-1:0], FI[WIDTH-1:Half]};
                s_upd_z = 1'b0;
            end
            OpBcf: begin
                s_fo    = FI & ~bit_mask;
                s_upd_z = 1'b0;
            end
            OpBsf: begin
                s_fo    = FI | bit_mask;
                s_upd_z = 1'b0;
            end
            OpBtf: s_fo = FI;
            default: begin
                // Unknown code: zero result, all flags hold
                s_fo    = '0;
                s_upd_z = 1'b0;
            end
        endcase
        s_z = (OP == OpBtf) ? ~FI[B] : (s_fo == '0);
    end

    // One shift-add (MUL) or restoring subtract-shift (DIV) step
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_s   = {hi_q, lo_q[WIDTH-1]};
        trial   = rem_s - {1'b0, opnd_q};
        if (div_q) begin
            // trial[WIDTH] set means the shifted remainder was below the divisor
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_s[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // FSM next state, result/flag/W updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        we_d    = we_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        w_d     = w_q;
        fo_d    = fo_q;
        fo_hi_d = fo_hi_q;
        co_d    = co_q;
        dc_d    = dc_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (START) begin
                    if (OP == OpMul) begin
                        div_d   = 1'b0;
                        we_d    = WE;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = w_q;
                        opnd_d  = FI;
                        state_d = StIter;
                    end else if (OP == OpDiv) begin
                        div_d = 1'b1;
                        we_d  = WE;
                        if (w_q == '0) begin
                            // Divide by zero resolves immediately
                            fo_d    = '1;
                            fo_hi_d = FI;
                            co_d    = 1'b1;
                            z_d     = 1'b0;
                            done_d  = 1'b1;
                            if (WE) begin
                                w_d = '1;
                            end
                            state_d = StFin;
                        end else begin
                            cnt_d   = '0;
                            hi_d    = '0;
                            lo_d    = FI;
                            opnd_d  = w_q;
                            state_d = StIter;
                        end
                    end else begin
                        fo_d    = s_fo;
                        fo_hi_d = '0;
                        done_d  = 1'b1;
                        if (s_upd_co) begin
                            co_d = s_co;
                        end
                        if (s_upd_dc) begin
                            dc_d = s_dc;
                        end
                        if (s_upd_z) begin
                            z_d = s_z;
                        end
                        if (WE) begin
                            w_d = s_fo;
                        end
                    end
                end
            end
            StIter: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + {{(BW-1){1'b0}}, 1'b1};
                if (cnt_q == BW'(WIDTH - 1)) begin
                    fo_d    = step_lo;
                    fo_hi_d = step_hi;
                    done_d  = 1'b1;
                    if (div_q) begin
                        co_d = 1'b0;
                        z_d  = (step_lo == '0);
                    end else begin
                        co_d = |step_hi;
                        z_d  = ~|{step_hi, step_lo};
                    end
                    if (we_q) begin
                        w_d = step_lo;
                    end
                    state_d = StFin;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            we_q    <= 1'b0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            w_q     <= '0;
            fo_q    <= '0;
            fo_hi_q <= '0;
            co_q    <= 1'b0;
            dc_q    <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            we_q    <= we_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            w_q     <= w_d;
            fo_q    <= fo_d;
            fo_hi_q <= fo_hi_d;
            co_q    <= co_d;
            dc_q    <= dc_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign BUSY  = (state_q != StIdle);
    assign DONE  = done_q;
    assign FO    = fo_q;
    assign FO_HI = fo_hi_q;
    assign CO    = co_q;
    assign DC    = dc_q;
    assign Z     = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven checks of alu_seq plus multi-cycle sequences.
module tb_alu_seq;

    localparam logic [4:0] OpPsw = 5'h00;
    localparam logic [4:0] OpClr = 5'h01;
    localparam logic [4:0] OpAdd = 5'h02;
    localparam logic [4:0] OpSub = 5'h03;
    localparam logic [4:0] OpDec = 5'h04;
    localparam logic [4:0] OpInc = 5'h05;
    localparam logic [4:0] OpIor = 5'h06;
    localparam logic [4:0] OpAnd = 5'h07;
    localparam logic [4:0] OpXor = 5'h08;
    localparam logic [4:0] OpPsf = 5'h09;
    localparam logic [4:0] OpCom = 5'h0A;
    localparam logic [4:0] OpRrf = 5'h0B;
    localparam logic [4:0] OpRlf = 5'h0C;
    localparam logic [4:0] OpSwp = 5'h0D;
    localparam logic [4:0] OpBcf = 5'h0E;
    localparam logic [4:0] OpBsf = 5'h0F;
    localparam logic [4:0] OpBtf = 5'h10;
    localparam logic [4:0] OpMul = 5'h11;
    localparam logic [4:0] OpDiv = 5'h12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       rst, start, we, ci;
    logic [4:0] op;
    logic [2:0] b;
    logic [7:0] fi;
    logic       busy, done, co, dc, z;
    logic [7:0] fo, fo_hi;

    // 16-bit instance
    logic        rst16, start16, we16, ci16;
    logic [4:0]  op16;
    logic [3:0]  b16;
    logic [15:0] fi16;
    logic        busy16, done16, co16, dc16, z16;
    logic [15:0] fo16, fo_hi16;

    alu_seq #(.WIDTH(8)) u_dut (
        .CLK(clk), .RST(rst), .START(start), .OP(op), .WE(we), .B(b), .FI(fi), .CI(ci),
        .BUSY(busy), .DONE(done), .FO(fo), .FO_HI(fo_hi), .CO(co), .DC(dc), .Z(z)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .CLK(clk), .RST(rst16), .START(start16), .OP(op16), .WE(we16), .B(b16), .FI(fi16),
        .CI(ci16), .BUSY(busy16), .DONE(done16), .FO(fo16), .FO_HI(fo_hi16), .CO(co16),
        .DC(dc16), .Z(z16)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one single-cycle op; returns at the sample point of cycle 1
    task automatic issue(input logic [4:0] o, input logic [7:0] f, input logic c,
                         input logic [2:0] bb, input logic w_e);
        @(negedge clk);
        op    = o;
        fi    = f;
        ci    = c;
        b     = bb;
        we    = w_e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic       ld;   // preload W with w via PSF first
        logic [7:0] w;
        logic [4:0] op;
        logic [7:0] fi;
        logic       ci;
        logic [2:0] b;
        logic       we;
        logic [7:0] fo;
        logic       co;
        logic       dc;
        logic       z;
    } vec_t;

    localparam int NumVec = 23;
    vec_t vecs[NumVec];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        int hit;
        // Expected flags include values held over from earlier vectors
        vecs[0]  = '{1'b1, 8'h0F, OpAdd, 8'h01, 1'b0, 3'd0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, OpPsw, 8'h00, 1'b0, 3'd0, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h05, OpSub, 8'h05, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 8'h06, OpSub, 8'h05, 1'b0, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h00, OpDec, 8'h00, 1'b0, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h01, OpInc, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'hF0, OpIor, 8'h0F, 1'b0, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'hF0, OpAnd, 8'h0F, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 8'hAA, OpXor, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h12, OpPsf, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'h12, OpCom, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'h33, OpClr, 8'h5A, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 8'h44, OpRrf, 8'h01, 1'b1, 3'd0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h00, OpRlf, 8'h80, 1'b1, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 8'h01, OpSwp, 8'hA5, 1'b0, 3'd0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 8'h00, OpBcf, 8'hFF, 1'b0, 3'd7, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 8'h00, OpBsf, 8'h00, 1'b0, 3'd2, 1'b0, 8'h04, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 8'h01, OpBtf, 8'h08, 1'b0, 3'd3, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 8'h01, OpBtf, 8'hF7, 1'b0, 3'd3, 1'b0, 8'hF7, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 8'h07, 5'h13, 8'h55, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 8'hFF, OpAdd, 8'h01, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[21] = '{1'b1, 8'h35, OpAdd, 8'h4A, 1'b0, 3'd0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 8'h02, OpPsw, 8'h77, 1'b0, 3'd0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; op = '0; we = 1'b0; ci = 1'b0; b = '0; fi = '0;
        rst16 = 1'b1; start16 = 1'b0; op16 = '0; we16 = 1'b0; ci16 = 1'b0; b16 = '0;
        fi16 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rst16 = 1'b0;
        @(negedge clk);
        chk("reset_state", {busy, done, fo, fo_hi, co, dc, z}, '0);

        // Table of single-cycle ops
        for (int i = 0; i < NumVec; i++) begin
            if (vecs[i].ld) begin
                issue(OpPsf, vecs[i].w, 1'b0, 3'd0, 1'b1);
            end
            issue(vecs[i].op, vecs[i].fi, vecs[i].ci, vecs[i].b, vecs[i].we);
            chk($sformatf("v%0d_done", i), done, 1'b1);
            chk($sformatf("v%0d_busy", i), busy, 1'b0);
            chk($sformatf("v%0d_fo", i), fo, vecs[i].fo);
            chk($sformatf("v%0d_fo_hi", i), fo_hi, 8'h00);
            chk($sformatf("v%0d_flags", i), {co, dc, z}, {vecs[i].co, vecs[i].dc, vecs[i].z});
        end

        // Back-to-back single-cycle ops
        @(negedge clk);
        op = OpPsf; fi = 8'h11; we = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("b2b_first_fo", fo, 8'h11);
        op = OpCom; fi = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_fo", fo, 8'hF0);
        chk("b2b_second_done", done, 1'b1);

        // MUL 0xFF*0xFF with an ignored START in cycle 4
        issue(OpPsf, 8'hFF, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        op = OpMul; fi = 8'hFF; we = 1'b1; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("mul_busy_c%0d", c), busy, (c <= 9) ? 1'b1 : 1'b0);
            chk($sformatf("mul_done_c%0d", c), done, (c == 9) ? 1'b1 : 1'b0);
            if (c == 3) begin
                chk("mul_fo_held", fo, 8'hFF);
            end
            if (c == 4) begin
                op = OpAdd; fi = 8'h00; start = 1'b1;
            end
            if (c == 9) begin
                chk("mul_result", {fo_hi, fo}, 16'hFE01);
                chk("mul_flags", {co, z}, 2'b10);
            end
        end
        issue(OpPsw, 8'h00, 1'b0, 3'd0, 1'b0);
        chk("mul_w_written", fo, 8'h01);

        // DIV 100/7
        issue(OpPsf, 8'h07, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        op = OpDiv; fi = 8'h64; we = 1'b1; start = 1'b1;
        hit = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                hit = c;
                break;
            end
        end
        chk("div_done_cycle", hit, 9);
        chk("div_result", {fo_hi, fo}, 16'h020E);
        chk("div_flags", {co, z}, 2'b00);
        issue(OpPsw, 8'h00, 1'b0, 3'd0, 1'b0);
        chk("div_w_written", fo, 8'h0E);

        // DIV by zero resolves in cycle 1
        issue(OpPsf, 8'h00, 1'b0, 3'd0, 1'b1);
        issue(OpDiv, 8'h3C, 1'b0, 3'd0, 1'b0);
        chk("div0_done", {done, busy}, 2'b11);
        chk("div0_result", {fo_hi, fo}, 16'h3CFF);
        chk("div0_flags", {co, z}, 2'b10);
        @(negedge clk);
        chk("div0_idle", {done, busy}, 2'b00);

        // Reset in cycle 4 of a MUL aborts it
        issue(OpPsf, 8'hFF, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        op = OpMul; fi = 8'hFF; we = 1'b1; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 4) begin
                rst = 1'b1;
            end
            if (c == 5) begin
                chk("rst_abort_state", {busy, done, fo, fo_hi, co, dc, z}, '0);
            end
        end
        rst = 1'b0;
        issue(OpPsw, 8'h00, 1'b0, 3'd0, 1'b0);
        chk("rst_w_cleared", {fo, z}, 9'h001);

        // 16-bit MUL 0xFFFF*0xFFFF
        @(negedge clk);
        op16 = OpPsf; fi16 = 16'hFFFF; we16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        op16 = OpMul; fi16 = 16'hFFFF; we16 = 1'b0; start16 = 1'b1;
        hit = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (done16) begin
                hit = c;
                break;
            end
        end
        chk("mul16_done_cycle", hit, 17);
        chk("mul16_result", {fo_hi16, fo16}, 32'hFFFE0001);
        chk("mul16_flags", {co16, z16, busy16}, 3'b101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
